seq_divider: RTL and testbench

- Parametrised multi-cycle restoring divider: dividend/divisor in, quotient and remainder out.
- Replaces the fixed 32-bit remainder-register datapath with a self-contained unit: own control FSM, iteration counter, Start/Ready handshake and divide-by-zero detection.
- Sits beside the ALU as the divide execution unit; the pipeline holds issue while Busy is high.

---
 rtl/seq_divider.sv | 145 ++++++++++++++
 tb/tb_seq_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with Start/Ready handshake and zero-divisor flag.
// Define SIGNED_DIV_EN to add the Signed_in port for two's complement operands.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend_in,
  input  logic [WIDTH-1:0] Divisor_in,
`ifdef SIGNED_DIV_EN
  input  logic             Signed_in,
`endif
  output logic             Busy,
  output logic             Ready,
  output logic             Div_by_zero,
  output logic [WIDTH-1:0] Quotient_out,
  output logic [WIDTH-1:0] Remainder_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmo_q, rmo_d;
  logic             dbz_q, dbz_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic             sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sh, trial, rem_nx;
  logic [WIDTH-1:0] q_sh, q_fin, r_fin;

  always_comb begin
`ifdef SIGNED_DIV_EN
    sgn = Signed_in;
`else
    sgn = 1'b0;
`endif
    a_neg = sgn & Dividend_in[WIDTH-1];
    b_neg = sgn & Divisor_in[WIDTH-1];
    a_mag = a_neg ? -Dividend_in : Dividend_in;
    b_mag = b_neg ? -Divisor_in : Divisor_in;
  end

  // One restoring step: shift {Rem,Q}, trial-subtract, keep or restore.
  always_comb begin
    sh     = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial  = sh - {1'b0, d_q};
    rem_nx = trial[WIDTH] ? sh : trial;
    q_sh   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
    q_fin  = negq_q ? -q_sh : q_sh;
    r_fin  = negr_q ? -rem_nx[WIDTH-1:0]
                    : rem_nx[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rmo_d   = rmo_q;
    dbz_d   = dbz_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    unique case (state_q)
      RUN: begin
        rem_d = rem_nx;
        q_d   = q_sh;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          quo_d   = q_fin;
          rmo_d   = r_fin;
          dbz_d   = 1'b0;
        end
      end
      IDLE, DONE: begin
        if (Start) begin
          if (Divisor_in == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rmo_d   = Dividend_in;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            rem_d   = '0;
            q_d     = a_mag;
            d_d     = b_mag;
            cnt_d   = CNT_W'(WIDTH);
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rmo_q   <= '0;
      dbz_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rmo_q   <= rmo_d;
      dbz_q   <= dbz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign Busy          = (state_q == RUN);
  assign Ready         = (state_q == DONE);
  assign Div_by_zero   = dbz_q;
  assign Quotient_out  = quo_q;
  assign Remainder_out = rmo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed table, handshake corner cases,
// and random operands against an arithmetic reference.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sgn_in = 1'b0;
  logic         busy, ready, dbz;
  logic [W-1:0] quo, rem;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .Reset_n      (rst_n),
    .Start        (start),
    .Dividend_in  (a),
    .Divisor_in   (b),
`ifdef SIGNED_DIV_EN
    .Signed_in    (sgn_in),
`endif
    .Busy         (busy),
    .Ready        (ready),
    .Div_by_zero  (dbz),
    .Quotient_out (quo),
    .Remainder_out(rem)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] x, y,
                                input logic s,
                                output logic [W-1:0] eq, er,
                                output logic ez);
    longint sx, sy;
    ez = (y == '0);
    if (ez) begin
      eq = '1;
      er = x;
    end else if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      eq = W'(sx / sy);
      er = W'(sx % sy);
    end else begin
      eq = x / y;
      er = x % y;
    end
  endfunction

  // Leaves the caller at the first falling edge after the accepting edge.
  task automatic launch(input logic [W-1:0] x, y, input logic s);
    @(negedge clk);
    a = x;
    b = y;
    sgn_in = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_ready(output int lat, output int bz);
    lat = 1;
    bz = 0;
    while (!ready && lat < 200) begin
      if (busy) bz++;
      @(negedge clk);
      lat++;
    end
    if (!ready) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_op(input string nm, input logic [W-1:0] x, y,
                          input logic s, input logic [W-1:0] eq, er,
                          input logic ez);
    int lat, bz;
    launch(x, y, s);
    wait_ready(lat, bz);
    chk({nm, "_quo"}, 64'(quo), 64'(eq));
    chk({nm, "_rem"}, 64'(rem), 64'(er));
    chk({nm, "_dbz"}, 64'(dbz), 64'(ez));
    chk({nm, "_lat"}, 64'(lat), ez ? 64'd1 : 64'(W + 1));
    chk({nm, "_busy"}, 64'(bz), ez ? 64'd0 : 64'(W));
  endtask

  initial begin
    logic [W-1:0] x, y, eq, er;
    logic s, ez;
    int lat, bz;

    tbl.push_back('{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0});
    tbl.push_back('{32'd5, 32'd10, 1'b0, 32'd0, 32'd5, 1'b0});
    tbl.push_back('{32'd1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd1234, 1'b1});
    tbl.push_back('{32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0});
    tbl.push_back('{32'd0, 32'd9, 1'b0, 32'd0, 32'd0, 1'b0});
    tbl.push_back('{32'd7, 32'd7, 1'b0, 32'd1, 32'd0, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 1'b0});
    tbl.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0});
    tbl.push_back('{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 32'd0, 32'hFFFFFFFE, 1'b0});
`ifdef SIGNED_DIV_EN
    tbl.push_back('{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
    tbl.push_back('{32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0});
    tbl.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0});
    tbl.push_back('{32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1});
    tbl.push_back('{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0});
`endif

    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    chk("rst_quo", 64'(quo), 64'd0);
    chk("rst_rem", 64'(rem), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s,
               tbl[i].q, tbl[i].r, tbl[i].z);

    // Back-to-back from DONE: old result stays visible through the new RUN.
    check_op("b2b_first", 32'hFFFFFFFF, 32'd1, 1'b0,
             32'hFFFFFFFF, 32'd0, 1'b0);
    launch(32'd5, 32'd10, 1'b0);
    chk("b2b_ready_drop", 64'(ready), 64'd0);
    chk("b2b_quo_hold", 64'(quo), 64'hFFFFFFFF);
    wait_ready(lat, bz);
    chk("b2b_lat", 64'(lat), 64'(W + 1));
    chk("b2b_quo", 64'(quo), 64'd0);
    chk("b2b_rem", 64'(rem), 64'd5);

    // Asynchronous reset in the middle of RUN.
    launch(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    chk("mid_busy_pre", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd0);
    chk("mid_rst_dbz", 64'(dbz), 64'd0);
    chk("mid_rst_quo", 64'(quo), 64'd0);
    chk("mid_rst_rem", 64'(rem), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_op("post_rst", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);

    // Start during RUN must be ignored.
    launch(32'd50, 32'd5, 1'b0);
    @(negedge clk);
    a = 32'd9;
    b = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(lat, bz);
    chk("ign_lat", 64'(lat + 2), 64'(W + 1));
    chk("ign_quo", 64'(quo), 64'd10);
    chk("ign_rem", 64'(rem), 64'd0);

    // Divide by zero from DONE: Busy must stay low.
    check_op("dbz_from_done", 32'd77, 32'd0, 1'b0,
             32'hFFFFFFFF, 32'd77, 1'b1);

    for (int i = 0; i < 60; i++) begin
      x = $urandom;
      if ($urandom_range(0, 9) == 0) y = '0;
      else if ($urandom_range(0, 1) == 0) y = W'($urandom_range(1, 15));
      else y = $urandom;
`ifdef SIGNED_DIV_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      model(x, y, s, eq, er, ez);
      check_op($sformatf("rnd%0d", i), x, y, s, eq, er, ez);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
